// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory stage.
//   - access size encodings (SZ_BYTE, SZ_HALF, SZ_WORD; encoding 3 behaves as word)
//   - FSM state type (idle, array access, response)
//   - is_aligned(): natural-alignment check for a size / low address pair
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAccess = 2'd1,
      StResp   = 2'd2
   } dmem_state_e;

   function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic ok;
      case (size)
         SZ_BYTE: ok = 1'b1;
         SZ_HALF: ok = ~addr_lo[0];
         default: ok = (addr_lo == 2'b00);
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational little-endian byte-lane steering.
//   Store path: size_i, addr_lo_i, wdata_i -> be_o (byte enables), wword_o (replicated data)
//   Load path : rword_i, addr_lo_i, size_i, sign_ext_i -> rdata_o (lane shifted to bit 0,
//               sign- or zero-extended; word loads pass through)
// Inputs are assumed aligned; misaligned accesses never reach the array.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  addr_lo_i,
   input  logic        sign_ext_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [3:0]  be_o,
   output logic [31:0] wword_o,
   output logic [31:0] rdata_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      be_o    = 4'b1111;
      wword_o = wdata_i;
      case (size_i)
         SZ_BYTE: begin
            be_o    = 4'b0001 << addr_lo_i;
            wword_o = {4{wdata_i[7:0]}};
         end
         SZ_HALF: begin
            be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wword_o = {2{wdata_i[15:0]}};
         end
         default: begin
            be_o    = 4'b1111;
            wword_o = wdata_i;
         end
      endcase
   end

   always_comb begin
      byte_sel = rword_i[{addr_lo_i, 3'b000} +: 8];
      half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
      case (size_i)
         SZ_BYTE: rdata_o = {{24{sign_ext_i & byte_sel[7]}}, byte_sel};
         SZ_HALF: rdata_o = {{16{sign_ext_i & half_sel[15]}}, half_sel};
         default: rdata_o = rword_i;
      endcase
   end

endmodule

// File: rtl/dmem_unit.sv
// dmem_unit: data-memory stage. One load or store per req/ack handshake.
//   clk_i, rst_i (async, active-low)
//   req_i, we_i, size_i, sign_ext_i, addr_i, wdata_i : request, sampled in idle only
//   rdata_o, ack_o, misalign_o : registered response, nonzero only in the ack cycle
//   busy_o : high whenever the FSM is not idle
// Aligned access: idle -> access (array read/write at exit edge) -> resp (ack).
// Misaligned access: idle -> resp with misalign set, array untouched.
module dmem_unit
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 128,
   parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [1:0]  size_i,
   input  logic        sign_ext_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        ack_o,
   output logic        misalign_o,
   output logic        busy_o
);

   dmem_state_e state_q, state_d;

   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              sign_q, sign_d;
   logic [IDX_W+1:0]  addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;

   logic [31:0]       rdata_q, rdata_d;
   logic              ack_q, ack_d;
   logic              mis_q, mis_d;

   logic [31:0]       mem [DEPTH_WORDS];
   logic [IDX_W-1:0]  idx;
   logic [31:0]       rword;
   logic [3:0]        be;
   logic [31:0]       wword;
   logic [31:0]       load_data;

   // Upper address bits wrap the address space and are deliberately dropped.
   logic unused_addr;
   assign unused_addr = ^addr_i[31:IDX_W+2];

   assign idx   = addr_q[IDX_W+1:2];
   assign rword = mem[idx];

   dmem_lane_align u_lane_align (
      .size_i     (size_q),
      .addr_lo_i  (addr_q[1:0]),
      .sign_ext_i (sign_q),
      .wdata_i    (wdata_q),
      .rword_i    (rword),
      .be_o       (be),
      .wword_o    (wword),
      .rdata_o    (load_data)
   );

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      size_d  = size_q;
      sign_d  = sign_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = '0;
      ack_d   = 1'b0;
      mis_d   = 1'b0;
      case (state_q)
         StIdle: begin
            if (req_i) begin
               we_d    = we_i;
               size_d  = size_i;
               sign_d  = sign_ext_i;
               addr_d  = addr_i[IDX_W+1:0];
               wdata_d = wdata_i;
               if (is_aligned(size_i, addr_i[1:0])) begin
                  state_d = StAccess;
               end else begin
                  state_d = StResp;
                  ack_d   = 1'b1;
                  mis_d   = 1'b1;
               end
            end
         end
         StAccess: begin
            state_d = StResp;
            ack_d   = 1'b1;
            rdata_d = we_q ? '0 : load_data;
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= StIdle;
         we_q    <= 1'b0;
         size_q  <= SZ_BYTE;
         sign_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ack_q   <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         size_q  <= size_d;
         sign_q  <= sign_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ack_q   <= ack_d;
         mis_q   <= mis_d;
      end
   end

   // Array is not reset. An async reset during access drops state_q out of
   // StAccess before the next edge, which aborts the pending store.
   always_ff @(posedge clk_i) begin
      if (state_q == StAccess && we_q) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
               mem[idx][8*b +: 8] <= wword[8*b +: 8];
            end
         end
      end
   end

   assign rdata_o    = rdata_q;
   assign ack_o      = ack_q;
   assign misalign_o = mis_q;
   assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_dmem_unit.sv
// tb_dmem_unit: self-checking bench for dmem_unit against a byte-array reference model.
module tb_dmem_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [1:0]  size = 2'd0;
   logic        sx = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        ack;
   logic        mis;
   logic        busy;

   int n_cmp = 0;
   int n_fail = 0;

   // Reference model: 128 words = 512 bytes, little-endian, address wraps at 512.
   logic [7:0] mem_m [512];

   always #5 clk = ~clk;

   dmem_unit u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .req_i      (req),
      .we_i       (we),
      .size_i     (size),
      .sign_ext_i (sx),
      .addr_i     (addr),
      .wdata_i    (wdata),
      .rdata_o    (rdata),
      .ack_o      (ack),
      .misalign_o (mis),
      .busy_o     (busy)
   );

   function automatic logic m_aligned(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'd0) return 1'b1;
      if (sz == 2'd1) return (a % 2) == 0;
      return (a % 4) == 0;
   endfunction

   function automatic int m_nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] m_load(input logic [1:0] sz, input logic s,
                                          input logic [31:0] a);
      logic [31:0] v;
      int n;
      n = m_nbytes(sz);
      v = '0;
      for (int k = 0; k < n; k++) v = v | (32'(mem_m[(a + k) % 512]) << (8 * k));
      if (s && n == 1 && v[7]) v = v | 32'hFFFF_FF00;
      if (s && n == 2 && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   task automatic m_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
      int n;
      n = m_nbytes(sz);
      for (int k = 0; k < n; k++) mem_m[(a + k) % 512] = d[8*k +: 8];
   endtask

   // Drives one request from idle; reports ack latency (cycles after acceptance),
   // busy cycles up to and including the ack cycle, and the response.
   task automatic issue(input logic w, input logic [1:0] sz, input logic s,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic mf,
                        output int lat, output int bcnt);
      @(negedge clk);
      req = 1'b1; we = w; size = sz; sx = s; addr = a; wdata = d;
      @(posedge clk);
      #1 req = 1'b0;
      lat = -1; bcnt = 0; rd = '0; mf = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (busy) bcnt++;
         if (ack) begin
            lat = c; rd = rdata; mf = mis;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (ack !== 1'b0 || mis !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: ack/mis/busy got %b%b%b expected 000", ack, mis, busy);
      end
      n_cmp++;
      if (rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_rdata: got %h expected 00000000", rdata);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_word;
      logic [31:0] rd; logic mf; int lat, bc;
      issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, rd, mf, lat, bc);
      m_store(2'd2, 32'h10, 32'hDEAD_BEEF);
      n_cmp++;
      if (lat !== 2 || bc !== 2 || mf !== 1'b0) begin
         n_fail++;
         $display("FAIL word_store: lat=%0d busy=%0d mis=%b expected 2 2 0", lat, bc, mf);
      end
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, mf, lat, bc);
      n_cmp++;
      if (lat !== 2 || bc !== 2 || rd !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL word_load: lat=%0d busy=%0d rdata=%h expected 2 2 deadbeef",
                  lat, bc, rd);
      end
      @(negedge clk);
      n_cmp++;
      if (ack !== 1'b0 || rdata !== 32'h0 || mis !== 1'b0) begin
         n_fail++;
         $display("FAIL post_ack_idle: ack=%b rdata=%h mis=%b expected 0 0 0", ack, rdata, mis);
      end
   endtask

   task automatic test_byte;
      logic [31:0] rd; logic mf; int lat, bc;
      issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_0080, rd, mf, lat, bc);
      m_store(2'd0, 32'h13, 32'h80);
      issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, rd, mf, lat, bc);
      n_cmp++;
      if (rd !== 32'hFFFF_FF80) begin
         n_fail++;
         $display("FAIL byte_load_signed: got %h expected ffffff80", rd);
      end
      issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, rd, mf, lat, bc);
      n_cmp++;
      if (rd !== 32'h0000_0080) begin
         n_fail++;
         $display("FAIL byte_load_unsigned: got %h expected 00000080", rd);
      end
      issue(1'b0, 2'd2, 1'b1, 32'h10, 32'h0, rd, mf, lat, bc);
      n_cmp++;
      if (rd !== 32'h80AD_BEEF) begin
         n_fail++;
         $display("FAIL byte_merge: got %h expected 80adbeef", rd);
      end
   endtask

   task automatic test_half_misalign;
      logic [31:0] rd; logic mf; int lat, bc;
      issue(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, rd, mf, lat, bc);
      n_cmp++;
      if (rd !== 32'hFFFF_80AD || mf !== 1'b0) begin
         n_fail++;
         $display("FAIL half_load_signed: got %h mis=%b expected ffff80ad 0", rd, mf);
      end
      issue(1'b0, 2'd1, 1'b1, 32'h11, 32'h0, rd, mf, lat, bc);
      n_cmp++;
      if (mf !== 1'b1 || rd !== 32'h0 || lat !== 1 || bc !== 1) begin
         n_fail++;
         $display("FAIL half_misalign: mis=%b rdata=%h lat=%0d busy=%0d expected 1 0 1 1",
                  mf, rd, lat, bc);
      end
      issue(1'b1, 2'd2, 1'b0, 32'h12, 32'h5555_5555, rd, mf, lat, bc);
      n_cmp++;
      if (mf !== 1'b1 || lat !== 1) begin
         n_fail++;
         $display("FAIL word_store_misalign: mis=%b lat=%0d expected 1 1", mf, lat);
      end
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, mf, lat, bc);
      n_cmp++;
      if (rd !== 32'h80AD_BEEF) begin
         n_fail++;
         $display("FAIL misalign_no_write: got %h expected 80adbeef", rd);
      end
   endtask

   task automatic test_wrap;
      logic [31:0] rd; logic mf; int lat, bc;
      issue(1'b1, 2'd2, 1'b0, 32'h200, 32'h1234_5678, rd, mf, lat, bc);
      m_store(2'd2, 32'h200, 32'h1234_5678);
      issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, rd, mf, lat, bc);
      n_cmp++;
      if (rd !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL wrap: got %h expected 12345678", rd);
      end
   endtask

   task automatic test_reset_abort;
      logic [31:0] rd; logic mf; int lat, bc, acks;
      issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344, rd, mf, lat, bc);
      m_store(2'd2, 32'h20, 32'h1122_3344);
      // Reset while the store is in its access cycle.
      @(negedge clk);
      req = 1'b1; we = 1'b1; size = 2'd2; sx = 1'b0; addr = 32'h20; wdata = 32'hCAFE_F00D;
      @(posedge clk);
      #1 req = 1'b0;
      #1 rst = 1'b0;
      #1;
      n_cmp++;
      if (ack !== 1'b0 || mis !== 1'b0 || busy !== 1'b0 || rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL abort_outputs: ack=%b mis=%b busy=%b rdata=%h expected all 0",
                  ack, mis, busy, rdata);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      acks = 0;
      repeat (4) begin
         @(negedge clk);
         if (ack) acks++;
      end
      n_cmp++;
      if (acks !== 0) begin
         n_fail++;
         $display("FAIL abort_no_ack: got %0d acks expected 0", acks);
      end
      issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, mf, lat, bc);
      n_cmp++;
      if (rd !== 32'h1122_3344) begin
         n_fail++;
         $display("FAIL abort_no_write: got %h expected 11223344", rd);
      end
      // Reset during the ack cycle: write already landed, ack dropped.
      @(negedge clk);
      req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h24; wdata = 32'hA5A5_0FF0;
      @(posedge clk);
      #1 req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      m_store(2'd2, 32'h24, 32'hA5A5_0FF0);
      rst = 1'b0;
      #1;
      n_cmp++;
      if (ack !== 1'b0) begin
         n_fail++;
         $display("FAIL resp_reset_ack: got %b expected 0", ack);
      end
      @(negedge clk);
      rst = 1'b1;
      issue(1'b0, 2'd2, 1'b0, 32'h24, 32'h0, rd, mf, lat, bc);
      n_cmp++;
      if (rd !== 32'hA5A5_0FF0) begin
         n_fail++;
         $display("FAIL resp_reset_write: got %h expected a5a50ff0", rd);
      end
   endtask

   task automatic test_random;
      logic [31:0] rd, r, a, d, exp; logic mf, w, s; logic [1:0] sz; int lat, bc;
      for (int i = 0; i < 32; i++) begin
         d = $urandom;
         a = 32'h100 + 32'(4 * i);
         issue(1'b1, 2'd2, 1'b0, a, d, rd, mf, lat, bc);
         m_store(2'd2, a, d);
      end
      for (int i = 0; i < 60; i++) begin
         r  = $urandom;
         w  = r[0];
         sz = r[2:1];
         s  = r[3];
         a  = ($urandom & 32'hFFFF_FE00) | (32'h100 + ($urandom % 128));
         d  = $urandom;
         issue(w, sz, s, a, d, rd, mf, lat, bc);
         if (!m_aligned(sz, a)) begin
            n_cmp++;
            if (mf !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
               n_fail++;
               $display("FAIL rand_misalign[%0d]: mis=%b rdata=%h lat=%0d expected 1 0 1",
                        i, mf, rd, lat);
            end
         end else if (w) begin
            m_store(sz, a, d);
            n_cmp++;
            if (mf !== 1'b0 || lat !== 2) begin
               n_fail++;
               $display("FAIL rand_store[%0d]: mis=%b lat=%0d expected 0 2", i, mf, lat);
            end
         end else begin
            exp = m_load(sz, s, a);
            n_cmp++;
            if (mf !== 1'b0 || lat !== 2 || rd !== exp) begin
               n_fail++;
               $display("FAIL rand_load[%0d] sz=%0d a=%h: rdata=%h mis=%b lat=%0d expected %h 0 2",
                        i, sz, a, rd, mf, lat, exp);
            end
         end
      end
   endtask

   task automatic bb_pick(input int k, output logic [31:0] exp);
      we = 1'b0;
      if (k % 2 == 0) begin
         size = 2'd2; sx = 1'b0;
         addr = 32'h100 + 32'(4 * ($urandom % 32));
      end else begin
         size = 2'd0; sx = 1'b1;
         addr = 32'h100 + ($urandom % 128);
      end
      exp = m_load(size, sx, addr);
   endtask

   task automatic test_back_to_back;
      logic [31:0] exp; int cyc, last, k;
      @(negedge clk);
      req = 1'b1;
      bb_pick(0, exp);
      cyc = 0; last = -1; k = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         cyc++;
         if (ack) begin
            n_cmp++;
            if (rdata !== exp) begin
               n_fail++;
               $display("FAIL b2b_data[%0d]: got %h expected %h", k, rdata, exp);
            end
            if (last >= 0) begin
               n_cmp++;
               if (cyc - last !== 3) begin
                  n_fail++;
                  $display("FAIL b2b_spacing[%0d]: got %0d cycles expected 3", k, cyc - last);
               end
            end
            last = cyc;
            k++;
            if (k == 6) begin
               req = 1'b0;
               break;
            end
            bb_pick(k, exp);
         end
      end
      req = 1'b0;
      n_cmp++;
      if (k !== 6) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d acks expected 6", k);
      end
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte();
      test_half_misalign();
      test_wrap();
      test_reset_abort();
      test_random();
      test_back_to_back();
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
